// File: rtl/data_memory_sized.sv
// Byte-addressed 32-bit data memory with byte/half/word lanes, READ_LAT-cycle valid-tagged responses.
// Optional alignment faulting enabled by defining DMEM_ALIGN_FAULT_EN; otherwise misaligned low bits are forced to 0.
module data_memory_sized #(
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              read_not_write_i,
    input  logic [1:0]        size_i,
    input  logic              signed_load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_in_i,
    output logic              ready_o,
    output logic              rsp_valid_o,
    output logic [31:0]       data_out_o,
    output logic              fault_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]         mem_q [DEPTH];
    logic                ready_q;
    logic [READ_LAT-1:0] vld_q;
    logic [READ_LAT-1:0] flt_q;
    logic [31:0]         dat_q [READ_LAT];

    logic             accept;
    logic             is_byte;
    logic             is_half;
    logic             misaligned;
    logic [1:0]       lo;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rword;
    logic [31:0]      shifted;
    logic [31:0]      rdata;
    logic [31:0]      dat_d;
    logic             unused_addr;

    assign accept      = req_i && ready_q;
    assign is_byte     = (size_i == 2'b00);
    assign is_half     = (size_i == 2'b01);
    assign idx         = addr_i[IDX_W+1:2];
    assign unused_addr = ^addr_i[ADDR_W-1:IDX_W+2];

`ifdef DMEM_ALIGN_FAULT_EN
    assign misaligned = (is_half && addr_i[0]) || (!is_byte && !is_half && (addr_i[1:0] != 2'b00));
    assign lo         = addr_i[1:0];
`else
    assign misaligned = 1'b0;
    assign lo         = is_byte ? addr_i[1:0] : (is_half ? {addr_i[1], 1'b0} : 2'b00);
`endif

    // Store data is replicated across lanes so the byte enables alone pick the destination.
    always_comb begin
        be    = 4'b1111;
        wdata = data_in_i;
        if (is_byte) begin
            be    = 4'b0001 << lo;
            wdata = {4{data_in_i[7:0]}};
        end else if (is_half) begin
            be    = 4'b0011 << lo;
            wdata = {2{data_in_i[15:0]}};
        end
        if (!accept || read_not_write_i || misaligned) begin
            be = 4'b0000;
        end
    end

    always_comb begin
        rword   = mem_q[idx];
        shifted = rword >> {lo, 3'b000};
        if (is_byte) begin
            rdata = {{24{signed_load_i & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            rdata = {{16{signed_load_i & shifted[15]}}, shifted[15:0]};
        end else begin
            rdata = rword;
        end
        dat_d = (accept && read_not_write_i && !misaligned) ? rdata : 32'h0;
    end

    // Array deliberately has no reset: contents must survive a reset pulse.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            vld_q   <= '0;
            flt_q   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            ready_q  <= 1'b1;
            vld_q[0] <= accept;
            flt_q[0] <= accept && misaligned;
            dat_q[0] <= dat_d;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                flt_q[i] <= flt_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign ready_o     = ready_q;
    assign rsp_valid_o = vld_q[READ_LAT-1];
    assign fault_o     = flt_q[READ_LAT-1];
    assign data_out_o  = dat_q[READ_LAT-1];
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed table-driven bench for data_memory_sized (READ_LAT=3), plus pipelining and reset sequences.
module tb_data_memory_sized;
    localparam int RL    = 3;
    localparam int DEPTH = 256;
`ifdef DMEM_ALIGN_FAULT_EN
    localparam bit AF = 1'b1;
`else
    localparam bit AF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        rnw = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        sgn = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] din = 32'h0;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] data_out;
    logic        fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rnw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dat;
        logic        exp_flt;
        string       name;
    } vec_t;

    vec_t vt[$];

    data_memory_sized #(.DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(RL)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req),
        .read_not_write_i (rnw),
        .size_i           (size),
        .signed_load_i    (sgn),
        .addr_i           (addr),
        .data_in_i        (din),
        .ready_o          (ready),
        .rsp_valid_o      (rsp_valid),
        .data_out_o       (data_out),
        .fault_o          (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] s, input logic sg, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] ed, input logic ef, input string n);
        vec_t v;
        v.rnw = r; v.size = s; v.sgn = sg; v.addr = a; v.din = d;
        v.exp_dat = ed; v.exp_flt = ef; v.name = n;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [1:0] s, input logic sg, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; rnw = r; size = s; sgn = sg; addr = a; din = d;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.rnw, v.size, v.sgn, v.addr, v.din);
        @(negedge clk);
        req = 1'b0;
        repeat (RL - 1) @(negedge clk);
        chk({v.name, " vld"}, {31'h0, rsp_valid}, 32'h1);
        chk({v.name, " dat"}, data_out, v.exp_dat);
        chk({v.name, " flt"}, {31'h0, fault}, {31'h0, v.exp_flt});
    endtask

    initial begin
        vt.push_back(mk(0, 2'b10, 0, 32'h10, 32'h12345678, 32'h0, 0, "str_w_10"));
        vt.push_back(mk(1, 2'b10, 0, 32'h10, 32'h0, 32'h12345678, 0, "ldr_w_10"));
        vt.push_back(mk(0, 2'b00, 0, 32'h11, 32'h000000AB, 32'h0, 0, "strb_11"));
        vt.push_back(mk(1, 2'b10, 0, 32'h10, 32'h0, 32'h1234AB78, 0, "ldr_after_strb"));
        vt.push_back(mk(1, 2'b00, 1, 32'h11, 32'h0, 32'hFFFFFFAB, 0, "ldrsb_11"));
        vt.push_back(mk(1, 2'b00, 0, 32'h11, 32'h0, 32'h000000AB, 0, "ldrb_11"));
        vt.push_back(mk(0, 2'b01, 0, 32'h12, 32'h00008001, 32'h0, 0, "strh_12"));
        vt.push_back(mk(1, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF8001, 0, "ldrsh_12"));
        vt.push_back(mk(1, 2'b01, 0, 32'h12, 32'h0, 32'h00008001, 0, "ldrh_12"));
        vt.push_back(mk(1, 2'b10, 0, 32'h10 + DEPTH*4, 32'h0, 32'h8001AB78, 0, "ldr_wrap"));
        vt.push_back(mk(1, 2'b11, 0, 32'h10, 32'h0, 32'h8001AB78, 0, "ldr_size11"));
        vt.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0BADC0DE, 32'h0, 0, "str_w_20"));
        vt.push_back(mk(1, 2'b10, 0, 32'h13, 32'h0, AF ? 32'h0 : 32'h8001AB78, AF, "ldr_mis_13"));
        vt.push_back(mk(1, 2'b01, 0, 32'h11, 32'h0, AF ? 32'h0 : 32'h0000AB78, AF, "ldrh_mis_11"));
        vt.push_back(mk(0, 2'b10, 0, 32'h22, 32'h5A5A5A5A, 32'h0, AF, "str_mis_22"));
        vt.push_back(mk(1, 2'b10, 0, 32'h20, 32'h0, AF ? 32'h0BADC0DE : 32'h5A5A5A5A, 0, "ldr_20_after_mis"));
        vt.push_back(mk(0, 2'b10, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0, "str_w_0"));
        vt.push_back(mk(0, 2'b10, 0, 32'h4, 32'h11111111, 32'h0, 0, "str_w_4"));
        vt.push_back(mk(0, 2'b10, 0, 32'h8, 32'h22222222, 32'h0, 0, "str_w_8"));
        vt.push_back(mk(0, 2'b00, 0, 32'h3, 32'hFFFFFF7F, 32'h0, 0, "strb_3_upper_ignored"));
        vt.push_back(mk(1, 2'b00, 1, 32'h3, 32'h0, 32'h0000007F, 0, "ldrsb_3_positive"));
        vt.push_back(mk(1, 2'b01, 1, 32'h0, 32'h0, 32'hFFFFF00D, 0, "ldrsh_0"));
        vt.push_back(mk(1, 2'b10, 0, 32'h0, 32'h0, 32'h7FFEF00D, 0, "ldr_w_0"));

        // Reset held with a request pending: nothing accepted, outputs quiet.
        drive(0, 2'b10, 0, 32'h40, 32'hFFFFFFFF);
        repeat (2) begin
            @(negedge clk);
            chk("rst ready", {31'h0, ready}, 32'h0);
            chk("rst vld", {31'h0, rsp_valid}, 32'h0);
            chk("rst dat", data_out, 32'h0);
        end
        req = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("release ready before edge", {31'h0, ready}, 32'h0);
        @(negedge clk);
        chk("release ready after edge", {31'h0, ready}, 32'h1);
        chk("release vld", {31'h0, rsp_valid}, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            run_vec(vt[i]);
        end

        // Store then load the same word on the next cycle.
        @(negedge clk);
        drive(0, 2'b10, 0, 32'h30, 32'hDEADBEEF);
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h30, 32'h0);
        @(negedge clk);
        req = 1'b0;
        chk("raw gap vld", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        chk("raw store vld", {31'h0, rsp_valid}, 32'h1);
        chk("raw store dat", data_out, 32'h0);
        @(negedge clk);
        chk("raw load vld", {31'h0, rsp_valid}, 32'h1);
        chk("raw load dat", data_out, 32'hDEADBEEF);

        // Back-to-back loads: three consecutive in-order responses.
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h4, 32'h0);
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h8, 32'h0);
        chk("b2b idle vld", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        req = 1'b0;
        chk("b2b0 vld", {31'h0, rsp_valid}, 32'h1);
        chk("b2b0 dat", data_out, 32'h7FFEF00D);
        @(negedge clk);
        chk("b2b1 vld", {31'h0, rsp_valid}, 32'h1);
        chk("b2b1 dat", data_out, 32'h11111111);
        @(negedge clk);
        chk("b2b2 vld", {31'h0, rsp_valid}, 32'h1);
        chk("b2b2 dat", data_out, 32'h22222222);
        @(negedge clk);
        chk("b2b after vld", {31'h0, rsp_valid}, 32'h0);

        // Reset with two loads still in flight, and a store offered during reset.
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h4, 32'h0);
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h8, 32'h0);
        @(negedge clk);
        chk("flight first vld", {31'h0, rsp_valid}, 32'h1);
        drive(0, 2'b10, 0, 32'h0, 32'h55555555);
        rst_n = 1'b0;
        #1;
        chk("flight rst vld", {31'h0, rsp_valid}, 32'h0);
        chk("flight rst dat", data_out, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("flight held vld", {31'h0, rsp_valid}, 32'h0);
        end
        req = 1'b0;
        rst_n = 1'b1;
        repeat (RL + 1) begin
            @(negedge clk);
            chk("flight post vld", {31'h0, rsp_valid}, 32'h0);
        end
        chk("flight post ready", {31'h0, ready}, 32'h1);
        run_vec(mk(1, 2'b10, 0, 32'h0, 32'h0, 32'h7FFEF00D, 0, "retained_0"));
        run_vec(mk(1, 2'b10, 0, 32'h8, 32'h0, 32'h22222222, 0, "retained_8"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
